line_buffer_window3: RTL and testbench
======================================

Name: line_buffer_window3

Overview:
- Streaming successor to the random-access 3x3 frame buffer.
- Accepts a raster pixel stream over a valid/ready handshake and keeps two line memories plus a 3x3 shift window.
- Emits one full 9-pixel window per frame pixel, with selectable border handling (zero or replicate), over its own valid/ready handshake.
- Sits between the grayscale conversion stage and the Sobel filter. It needs no row/column addressing from upstream.

Parameters:
- P_COLUMNS, 640: pixels per row (≥3).
- P_ROWS, 480: rows per frame (≥2).
- P_PIXEL_DEPTH, 4: input pixel width.
- P_WINDOW_PIXEL_DEPTH, 8: output pixel width (≥P_PIXEL_DEPTH); input is left-aligned and zero-padded in the LSBs.
- P_BORDER_MODE, 0: 0 = out-of-frame neighbours are 0; 1 = replicate the nearest in-frame pixel.
- P_COLUMNS_BITS, $clog2(P_COLUMNS): column counter width.
- P_ROWS_BITS, $clog2(P_ROWS): row counter width.

Ports:
- I_CLK  in  1  clock.
- I_RESET_N  in  1  asynchronous active-low reset.
- I_CLEAR  in  1  synchronous frame abort.
- I_PIXEL  in  P_PIXEL_DEPTH  raster input pixel.
- I_VALID  in  1  I_PIXEL valid.
- O_READY  out  1  block accepts I_PIXEL this cycle.
- O_WINDOW  out  9*P_WINDOW_PIXEL_DEPTH  {TL,T,TR,ML,C,MR,BL,B,BR}, TL in the MSBs.
- O_ROW  out  P_ROWS_BITS  centre row of O_WINDOW.
- O_COLUMN  out  P_COLUMNS_BITS  centre column of O_WINDOW.
- O_LAST  out  1  window is centred on (P_ROWS-1, P_COLUMNS-1).
- O_VALID  out  1  O_WINDOW/O_ROW/O_COLUMN/O_LAST valid.
- I_READY  in  1  downstream accepts the output.

Behaviour:
- Reset (I_RESET_N low, async): state FILL, counters 0, O_VALID=0, O_WINDOW=0, O_ROW=0, O_COLUMN=0, O_LAST=0.
- Line memories and window registers are not reset. Border muxing guarantees stale data never reaches O_WINDOW.
- Input accept = I_VALID & O_READY. Pixels arrive row-major; counters in_col/in_row wrap at P_COLUMNS/P_ROWS.
- Output stage advance = !O_VALID | I_READY. When advance is 0, nothing moves and all outputs hold stable.
- O_READY = advance & (state==FILL | state==RUN). O_READY is forced 0 in EOL and FLUSH.
- Column step: shift window left and insert column {line_top[c], line_mid[c], new}. Then write line_top[c] <= line_mid[c] and line_mid[c] <= new.
- States:
  - FILL (row 0): accept pixels, column steps, no output. After accepting (0, C-1) go to RUN.
  - RUN (rows 1..R-1): each accept of (r,c), c≥1, registers the window for centre (r-1, c-1) next cycle. After accepting (r, C-1) go to EOL.
  - EOL: one step, no input. Emits centre (r-1, C-1) with the right column bordered. Then go to RUN, or to FLUSH if r==R-1.
  - FLUSH: C column steps with the bottom column bordered. Step k≥1 emits centre (R-1, k-1). A final EOL-style step emits centre (R-1, C-1) with O_LAST=1. Then return to FILL.
- Windows per frame = P_ROWS*P_COLUMNS, emitted in raster order of the centre.
- Latency: the window for centre (y,x), x<C-1, is valid the cycle after (y+1, x+1) is accepted (stall-free). Each row costs C+1 cycles of input bandwidth.
- Border positions: top row when centre row=0; bottom row when centre row=R-1; left column when centre col=0; right column when centre col=C-1. Corners apply both row and column borders.
  - Mode 0: border pixels are 0.
  - Mode 1: a border row copies the centre row (column-bordered values applied first); a border column copies the centre column.
- Pixel format: out = {in, (P_WINDOW_PIXEL_DEPTH-P_PIXEL_DEPTH)'b0}.
- I_CLEAR (synchronous, takes priority over everything): state FILL, counters 0, O_VALID=0, O_LAST=0. Any held window is dropped.
- Async reset mid-frame: same as I_CLEAR, immediately.
- I_VALID low in FILL/RUN: no step, window registers hold.

Test Plan:
- P_COLUMNS=4, P_ROWS=3, P_PIXEL_DEPTH=4, P_WINDOW_PIXEL_DEPTH=8, mode 0; stream pixel (r,c) = 4r+c with I_READY=1 → exactly 12 windows in raster order; O_LAST only on (2,3).
- Same run, check specific windows:
  - Centre (1,1) = {0,1,2,4,5,6,8,9,10}<<4, valid the cycle after (2,2) is accepted.
  - Centre (0,0) = {0,0,0,0,0,1,0,4,5}<<4.
- Same stream, mode 1 → centre (0,0) = {0,0,1,0,0,1,4,4,5}<<4 and centre (2,3) = {6,7,7,10,11,11,10,11,11}<<4.
- Hold I_READY=0 for 5 cycles mid-row → O_READY=0 and O_WINDOW/O_ROW/O_COLUMN stable throughout; no window lost or duplicated.
- Random I_VALID gaps over 3 back-to-back frames → 36 windows, each matching a reference model; O_READY=0 during every EOL/FLUSH cycle.
- Assert I_CLEAR, then I_RESET_N low, each mid-row 1 → O_VALID=0 next cycle (immediately for reset); a fresh frame afterwards produces correct windows starting at centre (0,0).

Source files
------------

// File: rtl/line_buffer_window3_if.sv
// Handshake bundle for the 3x3 line-buffer window block.
// Input side: raster pixel stream. Output side: 9-pixel window with its centre coordinates.
interface line_buffer_window3_if #(
  parameter int P_COLUMNS            = 640,
  parameter int P_ROWS               = 480,
  parameter int P_PIXEL_DEPTH        = 4,
  parameter int P_WINDOW_PIXEL_DEPTH = 8,
  parameter int P_COLUMNS_BITS       = $clog2(P_COLUMNS),
  parameter int P_ROWS_BITS          = $clog2(P_ROWS)
);
  logic [P_PIXEL_DEPTH-1:0]          I_PIXEL;
  logic                              I_VALID;
  logic                              O_READY;
  logic [9*P_WINDOW_PIXEL_DEPTH-1:0] O_WINDOW;
  logic [P_ROWS_BITS-1:0]            O_ROW;
  logic [P_COLUMNS_BITS-1:0]         O_COLUMN;
  logic                              O_LAST;
  logic                              O_VALID;
  logic                              I_READY;

  // upstream/downstream environment side
  modport master (
    output I_PIXEL, I_VALID, I_READY,
    input  O_READY, O_WINDOW, O_ROW, O_COLUMN, O_LAST, O_VALID
  );

  // block side
  modport slave (
    input  I_PIXEL, I_VALID, I_READY,
    output O_READY, O_WINDOW, O_ROW, O_COLUMN, O_LAST, O_VALID
  );
endinterface

// File: rtl/line_buffer_window3.sv
// Streaming 3x3 window generator: two line memories plus a 3x3 shift window.
// Emits one bordered window per frame pixel in raster order of the centre.
module line_buffer_window3 #(
  parameter int P_COLUMNS            = 640,
  parameter int P_ROWS               = 480,
  parameter int P_PIXEL_DEPTH        = 4,
  parameter int P_WINDOW_PIXEL_DEPTH = 8,
  parameter int P_BORDER_MODE        = 0,
  parameter int P_COLUMNS_BITS       = $clog2(P_COLUMNS),
  parameter int P_ROWS_BITS          = $clog2(P_ROWS)
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET_N,
  input  logic                  I_CLEAR,
  line_buffer_window3_if.slave  bus
);
  localparam int PD = P_PIXEL_DEPTH;
  localparam int WD = P_WINDOW_PIXEL_DEPTH;
  localparam int CB = P_COLUMNS_BITS;
  localparam int RB = P_ROWS_BITS;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_EOL   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [CB-1:0] COL_MAX = CB'(P_COLUMNS - 1);
  localparam logic [RB-1:0] ROW_MAX = RB'(P_ROWS - 1);

  logic [1:0]    state;
  logic [CB-1:0] in_col;
  logic [RB-1:0] in_row;
  logic          last_eol;   // the pending EOL step is the frame's final one

  logic [PD-1:0] line_top [P_COLUMNS];
  logic [PD-1:0] line_mid [P_COLUMNS];

  // win[r][c]: r=0 top .. 2 bottom, c=0 left .. 2 right
  logic [2:0][2:0][PD-1:0] win, nwin;
  logic [2:0][PD-1:0]      col_in;
  logic [2:0][2:0][WD-1:0] bw;
  logic [9*WD-1:0]         win_flat;

  logic          advance, in_ready, accept, step, emit, last;
  logic [RB-1:0] crow;
  logic [CB-1:0] ccol;

  logic            out_valid, out_last;
  logic [9*WD-1:0] out_window;
  logic [RB-1:0]   out_row;
  logic [CB-1:0]   out_col;

  assign advance  = !out_valid | bus.I_READY;
  assign in_ready = advance & ((state == S_FILL) | (state == S_RUN));
  assign accept   = in_ready & bus.I_VALID;
  assign step     = accept | (advance & ((state == S_EOL) | (state == S_FLUSH)));

  assign bus.O_READY  = in_ready;
  assign bus.O_VALID  = out_valid;
  assign bus.O_WINDOW = out_window;
  assign bus.O_ROW    = out_row;
  assign bus.O_COLUMN = out_col;
  assign bus.O_LAST   = out_last;

  // decide whether this step emits a window and which centre it belongs to
  always_comb begin
    emit = 1'b0;
    last = 1'b0;
    crow = in_row - 1'b1;
    ccol = in_col - 1'b1;
    case (state)
      S_RUN:   emit = accept && (in_col != '0);
      S_EOL: begin
        emit = advance;
        ccol = COL_MAX;
        if (last_eol) begin
          crow = ROW_MAX;
          last = 1'b1;
        end
      end
      S_FLUSH: begin
        emit = advance && (in_col != '0);
        crow = ROW_MAX;
      end
      default: ;
    endcase
  end

  // window after one column step: shift left, new column enters on the right
  always_comb begin
    nwin      = win;
    col_in[0] = line_top[in_col];
    col_in[1] = line_mid[in_col];
    col_in[2] = bus.I_PIXEL;
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
      nwin[r][2] = col_in[r];
    end
  end

  // widen pixels, apply column borders then row borders, pack TL into the MSBs
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        bw[r][c] = WD'(nwin[r][c]) << (WD - PD);
    for (int r = 0; r < 3; r++) begin
      if (ccol == '0)     bw[r][0] = (P_BORDER_MODE == 1) ? bw[r][1] : '0;
      if (ccol == COL_MAX) bw[r][2] = (P_BORDER_MODE == 1) ? bw[r][1] : '0;
    end
    if (crow == '0)      bw[0] = (P_BORDER_MODE == 1) ? bw[1] : '0;
    if (crow == ROW_MAX) bw[2] = (P_BORDER_MODE == 1) ? bw[1] : '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_flat[(8 - (3*r + c))*WD +: WD] = bw[r][c];
  end

  // window shift register; stale contents are always masked by the border mux
  always_ff @(posedge I_CLK) begin
    if (step && !I_CLEAR) win <= nwin;
  end

  // line memories roll down one row on every accepted pixel
  always_ff @(posedge I_CLK) begin
    if (accept && !I_CLEAR) begin
      line_top[in_col] <= line_mid[in_col];
      line_mid[in_col] <= bus.I_PIXEL;
    end
  end

  // sequencing FSM, raster counters and output register
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state      <= S_FILL;
      in_col     <= '0;
      in_row     <= '0;
      last_eol   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (I_CLEAR) begin
      state     <= S_FILL;
      in_col    <= '0;
      in_row    <= '0;
      last_eol  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= emit;
        out_last  <= emit & last;
        if (emit) begin
          out_window <= win_flat;
          out_row    <= crow;
          out_col    <= ccol;
        end
      end
      case (state)
        S_FILL: if (accept) begin
          if (in_col == COL_MAX) begin
            in_col <= '0;
            in_row <= RB'(1);
            state  <= S_RUN;
          end else in_col <= in_col + 1'b1;
        end
        S_RUN: if (accept) begin
          if (in_col == COL_MAX) begin
            in_col <= '0;
            state  <= S_EOL;
          end else in_col <= in_col + 1'b1;
        end
        S_EOL: if (advance) begin
          if (last_eol) begin
            last_eol <= 1'b0;
            in_row   <= '0;
            state    <= S_FILL;
          end else if (in_row == ROW_MAX) begin
            state <= S_FLUSH;
          end else begin
            in_row <= in_row + 1'b1;
            state  <= S_RUN;
          end
        end
        S_FLUSH: if (advance) begin
          if (in_col == COL_MAX) begin
            in_col   <= '0;
            last_eol <= 1'b1;
            state    <= S_EOL;
          end else in_col <= in_col + 1'b1;
        end
        default: state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_line_buffer_window3.sv
// Bench for line_buffer_window3: 4x3 frames, zero and replicate border instances
// fed the same stream, windows compared with a clamp/zero neighbourhood model.
module tb_line_buffer_window3;
  localparam int C = 4;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst_n, clear;
  logic [3:0] pix;
  logic       i_valid, i_ready;

  int checks = 0;
  int errors = 0;

  logic [3:0] frames [0:8][0:R-1][0:C-1];
  int in_f, in_r, in_c, out_f, out_pos, blk;
  int lat_r, lat_c;
  bit lat_pending, stall_prev, got;
  logic [71:0] snap_win;
  logic [1:0]  snap_row, snap_col;

  always #5 clk = ~clk;

  line_buffer_window3_if #(.P_COLUMNS(C), .P_ROWS(R), .P_PIXEL_DEPTH(4), .P_WINDOW_PIXEL_DEPTH(8)) bus0 ();
  line_buffer_window3_if #(.P_COLUMNS(C), .P_ROWS(R), .P_PIXEL_DEPTH(4), .P_WINDOW_PIXEL_DEPTH(8)) bus1 ();

  assign bus0.I_PIXEL = pix;
  assign bus0.I_VALID = i_valid;
  assign bus0.I_READY = i_ready;
  assign bus1.I_PIXEL = pix;
  assign bus1.I_VALID = i_valid;
  assign bus1.I_READY = i_ready;

  line_buffer_window3 #(.P_COLUMNS(C), .P_ROWS(R), .P_PIXEL_DEPTH(4),
    .P_WINDOW_PIXEL_DEPTH(8), .P_BORDER_MODE(0)) dut0 (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_CLEAR(clear), .bus(bus0));

  line_buffer_window3 #(.P_COLUMNS(C), .P_ROWS(R), .P_PIXEL_DEPTH(4),
    .P_WINDOW_PIXEL_DEPTH(8), .P_BORDER_MODE(1)) dut1 (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_CLEAR(clear), .bus(bus1));

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // neighbourhood of (y,x): mode 0 zeroes outside pixels, mode 1 clamps to the frame
  function automatic logic [71:0] exp_win(int f, int y, int x, int mode);
    logic [71:0] w = '0;
    logic [3:0]  v;
    int yy, xx;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        yy = y + dy;
        xx = x + dx;
        if (mode == 1) begin
          yy = (yy < 0) ? 0 : (yy > R-1) ? R-1 : yy;
          xx = (xx < 0) ? 0 : (xx > C-1) ? C-1 : xx;
        end
        if (yy < 0 || yy >= R || xx < 0 || xx >= C) v = 4'h0;
        else v = frames[f][yy][xx];
        w[(8 - ((dy+1)*3 + (dx+1)))*8 +: 8] = {v, 4'h0};
      end
    return w;
  endfunction

  // one clock: present pixel, check outputs at negedge, account for accept after the edge
  task automatic tick(output bit acc);
    bit rdy;
    int y, x;
    pix = frames[in_f][in_r][in_c];
    @(negedge clk);
    chk("valid_modes_agree", bus1.O_VALID, bus0.O_VALID);
    chk("ready_modes_agree", bus1.O_READY, bus0.O_READY);
    if (lat_pending) begin
      chk("latency_valid", bus0.O_VALID, 1);
      chk("latency_row", bus0.O_ROW, lat_r);
      chk("latency_col", bus0.O_COLUMN, lat_c);
      lat_pending = 0;
    end
    if (blk > 0) begin
      chk("ready_low_eol_flush", bus0.O_READY, 0);
      blk--;
    end
    if (stall_prev) begin
      chk("stall_window", bus0.O_WINDOW, snap_win);
      chk("stall_row", bus0.O_ROW, snap_row);
      chk("stall_col", bus0.O_COLUMN, snap_col);
    end
    stall_prev = bus0.O_VALID && !i_ready;
    if (stall_prev) chk("stall_ready", bus0.O_READY, 0);
    snap_win = bus0.O_WINDOW;
    snap_row = bus0.O_ROW;
    snap_col = bus0.O_COLUMN;
    if (bus0.O_VALID === 1'b1 && i_ready) begin
      y = out_pos / C;
      x = out_pos % C;
      chk("out_row", bus0.O_ROW, y);
      chk("out_col", bus0.O_COLUMN, x);
      chk("out_last", bus0.O_LAST, (out_pos == R*C-1));
      chk("win_zero", bus0.O_WINDOW, exp_win(out_f, y, x, 0));
      chk("win_repl", bus1.O_WINDOW, exp_win(out_f, y, x, 1));
      if (out_f == 0 && y == 1 && x == 1)
        chk("f0_c11_zero", bus0.O_WINDOW, 72'h00_10_20_40_50_60_80_90_a0);
      if (out_f == 0 && y == 0 && x == 0) begin
        chk("f0_c00_zero", bus0.O_WINDOW, 72'h00_00_00_00_00_10_00_40_50);
        chk("f0_c00_repl", bus1.O_WINDOW, 72'h00_00_10_00_00_10_40_40_50);
      end
      if (out_f == 0 && y == 2 && x == 3)
        chk("f0_c23_repl", bus1.O_WINDOW, 72'h60_70_70_a0_b0_b0_a0_b0_b0);
      out_pos++;
      if (out_pos == R*C) begin
        out_pos = 0;
        out_f++;
      end
    end
    acc = i_valid && bus0.O_READY;
    rdy = i_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (rdy && in_r >= 1 && in_c >= 1) begin
        lat_pending = 1;
        lat_r = in_r - 1;
        lat_c = in_c - 1;
      end
      if (in_r >= 1 && in_c == C-1) blk = (in_r == R-1) ? C + 2 : 1;
      in_c++;
      if (in_c == C) begin
        in_c = 0;
        in_r++;
        if (in_r == R) begin
          in_r = 0;
          in_f++;
        end
      end
    end
  endtask

  task automatic feed(int n, int gap_pct);
    int tries;
    bit a;
    for (int k = 0; k < n; k++) begin
      tries = 0;
      a = 0;
      while (!a && tries < 64) begin
        i_valid = ($urandom_range(0, 99) >= gap_pct);
        tick(a);
        tries++;
      end
      if (!a) chk("feed_timeout", a, 1);
    end
    i_valid = 0;
  endtask

  task automatic drain(int target_f);
    int n = 0;
    bit a;
    i_valid = 0;
    while (out_f < target_f && n < 60) begin
      tick(a);
      n++;
    end
    chk("drain_frames", out_f, target_f);
    chk("drain_pos", out_pos, 0);
    repeat (3) tick(a);
  endtask

  task automatic resync(int f);
    in_f = f; in_r = 0; in_c = 0;
    out_f = f; out_pos = 0;
    blk = 0; lat_pending = 0; stall_prev = 0;
  endtask

  initial begin
    for (int f = 0; f <= 8; f++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          frames[f][r][c] = (f == 0) ? 4'(4*r + c) : 4'($urandom_range(0, 15));
    rst_n = 0; clear = 0; i_valid = 0; i_ready = 1; pix = 0;
    resync(0);

    // reset state
    #12;
    chk("rst_valid", bus0.O_VALID, 0);
    chk("rst_window", bus0.O_WINDOW, 0);
    chk("rst_row", bus0.O_ROW, 0);
    chk("rst_col", bus0.O_COLUMN, 0);
    chk("rst_last", bus0.O_LAST, 0);
    chk("rst_ready", bus0.O_READY, 1);
    @(posedge clk); #1;
    rst_n = 1;

    // frame 0: directed ramp, no gaps
    feed(R*C, 0);
    // frame 1: six pixels, downstream stall for five cycles, rest with gaps
    feed(6, 0);
    i_valid = 1; i_ready = 0;
    repeat (5) tick(got);
    i_ready = 1;
    feed(6, 30);
    // frames 2 and 3 back to back with random input gaps
    feed(R*C, 30);
    feed(R*C, 30);
    drain(4);

    // frame 4 aborted by clear in row 1, frame 5 fresh
    feed(6, 0);
    i_valid = 0; clear = 1;
    tick(got);
    clear = 0;
    resync(5);
    @(negedge clk);
    chk("clear_valid", bus0.O_VALID, 0);
    chk("clear_valid_repl", bus1.O_VALID, 0);
    chk("clear_last", bus0.O_LAST, 0);
    @(posedge clk); #1;
    feed(R*C, 30);
    drain(6);

    // frame 6 aborted by async reset in row 1, frame 7 fresh
    feed(6, 0);
    rst_n = 0;
    #1;
    chk("areset_valid", bus0.O_VALID, 0);
    chk("areset_window", bus0.O_WINDOW, 0);
    chk("areset_row", bus0.O_ROW, 0);
    chk("areset_col", bus0.O_COLUMN, 0);
    resync(7);
    @(posedge clk); #1;
    rst_n = 1;
    feed(R*C, 30);
    drain(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
